uart_frame_decoder: RTL
=======================

# uart_frame_decoder

Byte-to-frame decoder sitting directly downstream of `uart_rx`, consuming its `data_received`/`valid`/`ready` byte stream. Hunts for a sync byte, assembles a `SYNC, CMD, LEN, PAYLOAD[LEN], CSUM` frame, and verifies the XOR checksum. Presents each good frame as one parallel word on a valid/ready output. Malformed or stalled frames are dropped with a one-cycle error pulse, and the decoder resynchronises.

## Interface
- `MAX_PAYLOAD`, 8: maximum payload bytes per frame (1..16).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, 104_160: idle clocks allowed mid-frame before abort (two 10-bit characters at 9600 baud, 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `byte_in`  in  8  received byte (from `uart_rx` `data_received`).
- `byte_valid`  in  1  byte handshake valid (from `uart_rx` `valid`).
- `byte_ready`  out  1  byte handshake ready (to `uart_rx` `ready`).
- `out_cmd`  out  8  command byte of the accepted frame.
- `out_len`  out  `$clog2(MAX_PAYLOAD+1)`  payload length.
- `out_payload`  out  `8*MAX_PAYLOAD`  payload; byte i at `[8*i +: 8]`; bytes at index ≥ `out_len` are zero.
- `out_valid`  out  1  frame handshake valid.
- `out_ready`  in  1  frame handshake ready.
- `err_csum`  out  1  one-cycle pulse: checksum mismatch.
- `err_len`  out  1  one-cycle pulse: LEN > `MAX_PAYLOAD`.
- `err_timeout`  out  1  one-cycle pulse: mid-frame idle timeout.

## Operation
- A byte is accepted on a rising `clk` edge with `byte_valid && byte_ready`.
- `byte_ready = !rst && state != OUT`.
- States:
  - HUNT: accepted bytes ≠ `SYNC_BYTE` are discarded silently. On `SYNC_BYTE`, clear the payload buffer, reset the running checksum to 0, and go to CMD.
  - CMD: store the byte, `csum ^= byte`, go to LEN.
  - LEN: `csum ^= byte`.
    - If LEN > `MAX_PAYLOAD`, pulse `err_len` and go to HUNT.
    - If LEN == 0, store it and go to CSUM.
    - Otherwise store it, set idx=0, and go to PAYLOAD.
  - PAYLOAD: store the byte at idx, `csum ^= byte`, idx++. Go to CSUM after the byte where idx == LEN-1.
  - CSUM: if byte == running csum, load the output registers and go to OUT. Otherwise pulse `err_csum` and go to HUNT.
  - OUT: hold `out_valid=1` with all output fields stable. On `out_valid && out_ready`, go to HUNT.
- No byte escaping: `SYNC_BYTE` appearing inside CMD, LEN, PAYLOAD or CSUM is ordinary data.
- Timeout: in CMD, LEN, PAYLOAD and CSUM, an idle counter clears on every accepted byte and increments otherwise. When it reaches `TIMEOUT_CLKS`, pulse `err_timeout`, clear the counter, and go to HUNT. The counter is held at 0 in HUNT and OUT.
- Error pulses are mutually exclusive and never coincide with `out_valid` rising.

## Timing
- Reset values:
  - state HUNT.
  - `out_valid=0`, `out_cmd=0`, `out_len=0`, `out_payload=0`.
  - All `err_*` = 0.
  - `byte_ready=0` while `rst` is high; 1 on the first cycle after `rst` falls.
- `rst` asserted mid-frame or in OUT discards everything. No error pulse is generated.
- Latency:
  - `out_valid` rises on the cycle after the CSUM byte is accepted.
  - `err_csum`/`err_len` are high exactly one cycle, on the cycle after the offending byte is accepted.
  - `err_timeout` is high for one cycle, `TIMEOUT_CLKS` cycles after the last accepted byte.
- OUT transfer cycle: `out_valid` is 0 and `byte_ready` is 1 on the next cycle. The earliest next SYNC is accepted one cycle after the transfer.
- Backpressure: in OUT, `byte_ready=0` for as long as `out_ready` is low. `uart_rx` holds its byte; this block drops nothing.
- `out_*` fields change only when entering OUT. They keep their last frame's value afterward.

## Test plan
- Good frame: bytes A5 01 02 11 22 30 → `out_valid`=1 one cycle after 0x30, with `out_cmd`=01, `out_len`=2, `out_payload[15:0]`=16'h2211 and upper bytes 0. Transfer with `out_ready`=1.
- Garbage then empty frame: 00 FF 3C A5 07 00 07 → leading bytes ignored; frame with `out_cmd`=07, `out_len`=0, `out_payload`=0.
- Errors:
  - A5 01 02 11 22 31 → `err_csum` for one cycle, no `out_valid`.
  - A5 01 09 (`MAX_PAYLOAD`=8) → `err_len` for one cycle.
  - A following good frame decodes correctly after each error.
- Backpressure: good frame with `out_ready`=0 for 100 cycles → `out_valid` and fields stable and `byte_ready`=0 throughout. A queued A5 is accepted only after `out_ready` rises.
- Timeout (`TIMEOUT_CLKS`=50): send A5 01 then stall → `err_timeout` exactly 50 cycles after the 01 byte. A subsequent good frame decodes.
- Loopback: `uart_tx` → `uart_rx` → decoder at 9600 baud, frame A5 10 01 A5 B4 → `out_cmd`=10, `out_len`=1, payload byte A5. Also assert `rst` mid-PAYLOAD of a second frame → no outputs or error pulses, clean decode afterward.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// Frame decoder fed by a UART byte stream: finds SYNC, assembles CMD/LEN/PAYLOAD/CSUM,
// checks the XOR checksum and presents each good frame as one parallel word.
module uart_frame_decoder #(
    parameter int          MAX_PAYLOAD  = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 104_160,
    localparam int         LEN_W        = $clog2(MAX_PAYLOAD + 1),
    localparam int         CNT_W        = $clog2(TIMEOUT_CLKS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic [7:0]               out_cmd,
    output logic [LEN_W-1:0]         out_len,
    output logic [8*MAX_PAYLOAD-1:0] out_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_csum,
    output logic                     err_len,
    output logic                     err_timeout
);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_OUT
    } state_t;

    state_t                   state_reg, state_next;
    logic [7:0]               csum_reg, csum_next;
    logic [7:0]               cmd_reg, cmd_next;
    logic [LEN_W-1:0]         len_reg, len_next;
    logic [LEN_W-1:0]         idx_reg, idx_next;
    logic [8*MAX_PAYLOAD-1:0] pay_reg, pay_next;
    logic [CNT_W-1:0]         idle_reg, idle_next;
    logic [7:0]               out_cmd_reg, out_cmd_next;
    logic [LEN_W-1:0]         out_len_reg, out_len_next;
    logic [8*MAX_PAYLOAD-1:0] out_payload_reg, out_payload_next;
    logic                     err_csum_reg, err_csum_next;
    logic                     err_len_reg, err_len_next;
    logic                     err_timeout_reg, err_timeout_next;
    logic                     accept;
    logic [MAX_PAYLOAD-1:0]   slot_sel;

    assign byte_ready  = !rst && (state_reg != ST_OUT);
    assign accept      = byte_valid && byte_ready;
    assign out_valid   = (state_reg == ST_OUT);
    assign out_cmd     = out_cmd_reg;
    assign out_len     = out_len_reg;
    assign out_payload = out_payload_reg;
    assign err_csum    = err_csum_reg;
    assign err_len     = err_len_reg;
    assign err_timeout = err_timeout_reg;

    // One-hot decode of the payload slot addressed by the current index.
    generate
        for (genvar gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_slot
            assign slot_sel[gi] = (idx_reg == LEN_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_HUNT;
            csum_reg        <= '0;
            cmd_reg         <= '0;
            len_reg         <= '0;
            idx_reg         <= '0;
            pay_reg         <= '0;
            idle_reg        <= '0;
            out_cmd_reg     <= '0;
            out_len_reg     <= '0;
            out_payload_reg <= '0;
            err_csum_reg    <= 1'b0;
            err_len_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            csum_reg        <= csum_next;
            cmd_reg         <= cmd_next;
            len_reg         <= len_next;
            idx_reg         <= idx_next;
            pay_reg         <= pay_next;
            idle_reg        <= idle_next;
            out_cmd_reg     <= out_cmd_next;
            out_len_reg     <= out_len_next;
            out_payload_reg <= out_payload_next;
            err_csum_reg    <= err_csum_next;
            err_len_reg     <= err_len_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        csum_next        = csum_reg;
        cmd_next         = cmd_reg;
        len_next         = len_reg;
        idx_next         = idx_reg;
        pay_next         = pay_reg;
        idle_next        = idle_reg;
        out_cmd_next     = out_cmd_reg;
        out_len_next     = out_len_reg;
        out_payload_next = out_payload_reg;
        err_csum_next    = 1'b0;
        err_len_next     = 1'b0;
        err_timeout_next = 1'b0;

        case (state_reg)
            ST_HUNT: begin
                idle_next = '0;
                if (accept && byte_in == SYNC_BYTE) begin
                    pay_next   = '0;
                    csum_next  = '0;
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (accept) begin
                    cmd_next   = byte_in;
                    csum_next  = csum_reg ^ byte_in;
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    csum_next = csum_reg ^ byte_in;
                    if (int'(byte_in) > MAX_PAYLOAD) begin
                        err_len_next = 1'b1;
                        state_next   = ST_HUNT;
                    end else begin
                        len_next   = byte_in[LEN_W-1:0];
                        idx_next   = '0;
                        state_next = (byte_in == 8'd0) ? ST_CSUM : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (slot_sel[i]) begin
                            pay_next[8*i +: 8] = byte_in;
                        end
                    end
                    csum_next = csum_reg ^ byte_in;
                    idx_next  = idx_reg + LEN_W'(1);
                    if (idx_reg == len_reg - LEN_W'(1)) begin
                        state_next = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (byte_in == csum_reg) begin
                        out_cmd_next     = cmd_reg;
                        out_len_next     = len_reg;
                        out_payload_next = pay_reg;
                        state_next       = ST_OUT;
                    end else begin
                        err_csum_next = 1'b1;
                        state_next    = ST_HUNT;
                    end
                end
            end
            ST_OUT: begin
                idle_next = '0;
                if (out_ready) begin
                    state_next = ST_HUNT;
                end
            end
            default: state_next = ST_HUNT;
        endcase

        // Mid-frame watchdog; the pulse lands TIMEOUT_CLKS cycles after the last accepted byte.
        if (state_reg inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CSUM}) begin
            if (accept) begin
                idle_next = '0;
            end else if (idle_reg == CNT_W'(TIMEOUT_CLKS - 1)) begin
                idle_next        = '0;
                err_timeout_next = 1'b1;
                state_next       = ST_HUNT;
            end else begin
                idle_next = idle_reg + CNT_W'(1);
            end
        end
    end

endmodule
